// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command issuer: ALU selects, instruction
// kinds, instruction field positions and the issuer FSM state encoding.
package alu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_DIV = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam logic [1:0] KIND_ALU   = 2'b00;
  localparam logic [1:0] KIND_LOADI = 2'b01;
  localparam logic [1:0] KIND_READ  = 2'b10;
  localparam logic [1:0] KIND_RSV   = 2'b11;

  // imm overlaps srcb: LOADI reuses the low byte as its immediate
  localparam int KIND_LSB = 14;
  localparam int SEL_LSB  = 12;
  localparam int DST_LSB  = 10;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_LSB = 6;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Instruction and response valid/ready channels of the ALU issuer; the issuer is the
// slave, the instruction source / result consumer is the master.
interface alu_op_issuer_if #(
  parameter int DW = 8
);
  import alu_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic               res_valid;
  logic               res_ready;
  logic [DW-1:0]      res_data;
  logic               res_dz;
  logic               res_err;

  modport master (
    output instr_valid, instr_data, res_ready,
    input  instr_ready, res_valid, res_data, res_dz, res_err
  );

  modport slave (
    input  instr_valid, instr_data, res_ready,
    output instr_ready, res_valid, res_data, res_dz, res_err
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port,
// cleared by the asynchronous reset.
module alu_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  localparam int RAW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [RAW-1:0] raddr_a_i,
  input  logic [RAW-1:0] raddr_b_i,
  output logic [DW-1:0]  rdata_a_o,
  output logic [DW-1:0]  rdata_b_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_op_issuer.sv
// Command front end for the combinational ALU: accepts one instruction at a time, drives
// the ALU from the register file, writes the result back and returns it as a response.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_op_issuer_if.slave bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_result
);

  localparam int RAW = $clog2(NREG);

  state_e             state_q;
  logic [INSTR_W-1:0] instr_q;
  logic               res_valid_q;
  logic [DW-1:0]      res_data_q, res_data_d;
  logic               res_dz_q, res_dz_d;
  logic               res_err_q, res_err_d;

  logic [1:0]     kind, sel;
  logic [RAW-1:0] dst, srca, srcb;
  logic [DW-1:0]  imm, rd_a, rd_b;
  logic           wr_en, alu_active;

  assign kind = instr_q[KIND_LSB +: 2];
  assign sel  = instr_q[SEL_LSB +: 2];
  assign dst  = instr_q[DST_LSB +: RAW];
  assign srca = instr_q[SRCA_LSB +: RAW];
  assign srcb = instr_q[SRCB_LSB +: RAW];
  assign imm  = DW'(instr_q[IMM_LSB +: IMM_W]);

  alu_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_en),
    .waddr_i   (dst),
    .wdata_i   (res_data_d),
    .raddr_a_i (srca),
    .raddr_b_i (srcb),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  // The register file is only written at the end of CAPT, so the operands stay stable
  // across ISSUE and CAPT even when dst aliases a source.
  assign alu_active = (state_q == ST_ISSUE) || (state_q == ST_CAPT);
  assign alu_a      = alu_active ? rd_a : '0;
  assign alu_b      = alu_active ? rd_b : '0;
  assign alu_sel    = alu_active ? sel  : 2'b00;

  always_comb begin
    res_data_d = '0;
    res_dz_d   = 1'b0;
    res_err_d  = 1'b0;
    wr_en      = 1'b0;
    case (kind)
      KIND_ALU: begin
        wr_en = 1'b1;
        if (sel == ALU_DIV && rd_b == '0) res_dz_d = 1'b1;
        else                              res_data_d = alu_result;
      end
      KIND_LOADI: begin
        wr_en      = 1'b1;
        res_data_d = imm;
      end
      KIND_READ: res_data_d = rd_a;
      default:   res_err_d  = 1'b1;
    endcase
    wr_en = wr_en && (state_q == ST_CAPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dz_q    <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr_data;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_CAPT;
        ST_CAPT: begin
          res_data_q  <= res_data_d;
          res_dz_q    <= res_dz_d;
          res_err_q   <= res_err_d;
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_dz      = res_dz_q;
  assign bus.res_err     = res_err_q;

endmodule
